wb_port_arbiter: RTL and testbench

- Sole writer of the register-file write port (A3/WD3/RegWEn).
- Merges two result sources onto that single port:
  - single-cycle ALU results, which have priority;
  - long-latency results (loads, multi-cycle mul/div), buffered in a small FIFO.
- Sits between the execute/memory stages and the register file.
- Includes a starvation guard that stalls the ALU path so buffered results always retire.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/wb_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back port arbiter: result entry, arbiter state,
// and a helper that turns a destination register into a one-hot mask.
// Optional build macro used by the users of this package: WB_PENDING_MASK_EN.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  // One buffered long-latency result.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_t;

  // One-hot of a register index; x0 never counts as pending.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [NREGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO buffering long-latency results for the write port.
// Ports: clk/rst_n, push_i/push_dat_i, pop_i, full_o/empty_o, head_o (current
// oldest entry); with WB_PENDING_MASK_EN also per-entry valid and rd vectors.
// Pushes when full and pops when empty are ignored; no bypass (head is
// visible the cycle after the push).
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_dat_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [DEPTH-1:0]             ent_vld_o,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_rd_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

`ifdef WB_PENDING_MASK_EN
  // Slot g is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [AW-1:0] off;
    assign off          = AW'(g) - rd_ptr_q;
    assign ent_vld_o[g] = ({1'b0, off} < cnt_q);
    assign ent_rd_o[g]  = mem_q[g].rd;
  end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Sole writer of the register-file write port: merges single-cycle ALU
// results (priority) with buffered long-latency results, with a starvation
// guard that stalls the ALU for one pop when the FIFO head waits too long.
// Ports: clock/Reset; alu_valid/alu_rd/alu_data in, alu_stall out;
// ll_valid/ll_rd/ll_data in, ll_ready out; A3/WD3/RegWEn registered write
// port; pend_mask (only with WB_PENDING_MASK_EN) lists in-flight registers.
// Latency 1 from selection to the write port registers.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_stall,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_AW-1:0] ll_rd,
  input  logic [XLEN-1:0]   ll_data,
  output logic [REG_AW-1:0] A3,
  output logic [XLEN-1:0]   WD3,
  output logic              RegWEn
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [XLEN-1:0]   pend_mask
`endif
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  wb_state_t         state_q, state_d;
  logic [AGE_W-1:0]  age_q,   age_d;
  logic              stall_q, stall_d;
  logic              we_q,    we_d;
  logic [REG_AW-1:0] a3_q,    a3_d;
  logic [XLEN-1:0]   wd3_q,   wd3_d;

  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t fifo_head;
  wb_entry_t push_dat;
  logic      push;
  logic      pop;
  logic      alu_win;
  logic      head_blocked;

`ifdef WB_PENDING_MASK_EN
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
`endif

  // x0 results handshake normally but never reach the FIFO.
  assign ll_ready      = ~fifo_full;
  assign push          = ll_valid & ~fifo_full & (ll_rd != '0);
  assign push_dat.rd   = ll_rd;
  assign push_dat.data = ll_data;

  // ALU only wins in NORMAL and only for a real destination; any cycle it
  // does not win, a non-empty FIFO retires its head.
  assign alu_win      = (state_q == NORMAL) & alu_valid & (alu_rd != '0);
  assign pop          = ~fifo_empty & ~alu_win;
  assign head_blocked = ~fifo_empty & ~pop;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clock),
    .rst_n      (Reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
`ifdef WB_PENDING_MASK_EN
    ,
    .ent_vld_o  (ent_vld),
    .ent_rd_o   (ent_rd)
`endif
  );

  // Age of the FIFO head: cycles it has been passed over, saturating.
  always_comb begin
    age_d = age_q;
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q != AGE_W'(STARVE_LIMIT)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    a3_d    = a3_q;
    wd3_d   = wd3_q;

    if (alu_win) begin
      we_d  = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (pop) begin
      we_d  = 1'b1;
      a3_d  = fifo_head.rd;
      wd3_d = fifo_head.data;
    end

    case (state_q)
      NORMAL: begin
        // The head is about to be blocked for the STARVE_LIMIT-th time.
        if (head_blocked && (age_q == AGE_W'(STARVE_LIMIT - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase

    stall_d = (state_d == DRAIN);
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= NORMAL;
      age_q   <= '0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  assign alu_stall = stall_q;
  assign RegWEn    = we_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;

`ifdef WB_PENDING_MASK_EN
  // Registers still to be written: queued entries plus the write in flight.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pend_mask = pend_mask | reg_onehot(ent_rd[i]);
    end
    if (we_q) pend_mask = pend_mask | reg_onehot(a3_q);
    pend_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        Reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        RegWEn;
`ifdef WB_PENDING_MASK_EN
  logic [31:0] pend_mask;
`endif

  wb_port_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock     (clock),
    .Reset     (Reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .ll_valid  (ll_valid),
    .ll_ready  (ll_ready),
    .ll_rd     (ll_rd),
    .ll_data   (ll_data),
    .A3        (A3),
    .WD3       (WD3),
    .RegWEn    (RegWEn)
`ifdef WB_PENDING_MASK_EN
    ,
    .pend_mask (pend_mask)
`endif
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue of pending results, how long the oldest one
  // has been passed over, and whether the ALU is currently being held off.
  logic [4:0]  m_rd  [$];
  logic [31:0] m_dat [$];
  int          m_wait;
  bit          m_drain;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd.delete();
    m_dat.delete();
    m_wait  = 0;
    m_drain = 0;
    m_we    = 1'b0;
    m_a3    = '0;
    m_wd    = '0;
  endtask

  task automatic check_all(input string ph);
`ifdef WB_PENDING_MASK_EN
    logic [31:0] em;
`endif
    chk({ph, ".RegWEn"}, 32'(RegWEn), 32'(m_we));
    chk({ph, ".A3"}, 32'(A3), 32'(m_a3));
    chk({ph, ".WD3"}, WD3, m_wd);
    chk({ph, ".alu_stall"}, 32'(alu_stall), 32'(m_drain));
    chk({ph, ".ll_ready"}, 32'(ll_ready), 32'(m_rd.size() < DEPTH));
`ifdef WB_PENDING_MASK_EN
    em = '0;
    foreach (m_rd[i]) em[m_rd[i]] = 1'b1;
    if (m_we) em[m_a3] = 1'b1;
    em[0] = 1'b0;
    chk({ph, ".pend_mask"}, pend_mask, em);
`endif
  endtask

  // Drive one cycle of inputs, predict its effect, clock, then compare.
  task automatic step(input string ph,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    int sz;
    bit alu_win, pop, push;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ll_valid  = lv; ll_rd  = lr; ll_data  = ld;

    sz       = m_rd.size();
    last_acc = lv && (sz < DEPTH);
    push     = last_acc && (lr != 5'd0);
    alu_win  = !m_drain && av && (ar != 5'd0);
    pop      = (sz > 0) && !alu_win;

    if (alu_win) begin
      m_we = 1'b1; m_a3 = ar; m_wd = ad;
    end else if (pop) begin
      m_we = 1'b1; m_a3 = m_rd[0]; m_wd = m_dat[0];
    end else begin
      m_we = 1'b0;
    end

    if (pop) begin
      void'(m_rd.pop_front());
      void'(m_dat.pop_front());
      m_wait  = 0;
      m_drain = 0;
    end else if (sz > 0) begin
      m_wait++;
      if (m_wait >= LIMIT) m_drain = 1;
    end else begin
      m_wait = 0;
    end
    if (push) begin
      m_rd.push_back(lr);
      m_dat.push_back(ld);
    end

    @(posedge clock);
    #1;
    check_all(ph);
  endtask

  initial begin
    int idx;
    int wr_idx;
    logic av;

    // Reset values, before any clock edge.
    model_reset();
    #2;
    check_all("reset");
    #2 Reset = 1'b1;

    // Single ALU write, then idle.
    step("alu", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    chk("alu_a3", 32'(A3), 32'd5);
    chk("alu_wd3", WD3, 32'hDEADBEEF);
    step("alu_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("alu_idle_we", 32'(RegWEn), 32'd0);

    // x0 discards on both paths.
    step("x0_alu", 1, 5'd0, 32'h55, 0, 5'd0, 32'h0);
    chk("x0_alu_we", 32'(RegWEn), 32'd0);
    step("x0_ll", 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234);
    step("x0_ll_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("x0_ll_we", 32'(RegWEn), 32'd0);

    // Collision: ALU first, buffered result the following cycle.
    step("coll0", 1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
    chk("coll0_a3", 32'(A3), 32'd3);
    step("coll1", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("coll1_a3", 32'(A3), 32'd7);
    chk("coll1_wd3", WD3, 32'h22);

    // Fill the FIFO behind a busy ALU; drain order must follow push order.
    idx = 0;
    wr_idx = 0;
    for (int c = 0; c < 14; c++) begin
      step("full", c < 6, 5'd20, 32'(c), idx < 5, 5'(8 + idx), 32'h100 + 32'(idx));
      if (last_acc && idx < 5) idx++;
      if (c == 3) chk("full_ready_low", 32'(ll_ready), 32'd0);
      if (RegWEn && A3 >= 5'd8 && A3 <= 5'd12) begin
        chk("full_order", 32'(A3), 32'(8 + wr_idx));
        wr_idx++;
      end
    end
    chk("full_count", 32'(wr_idx), 32'd5);

    // Starvation: one buffered result behind a continuously busy ALU.
    step("starve_push", 1, 5'd4, 32'h1, 1, 5'd9, 32'hCAFE);
    for (int c = 1; c < 9; c++) begin
      chk("starve_wait", 32'(alu_stall), 32'd0);
      step("starve", 1, 5'd4, 32'(c), 0, 5'd0, 32'h0);
    end
    chk("starve_stall", 32'(alu_stall), 32'd1);
`ifdef WB_PENDING_MASK_EN
    chk("starve_pend9", 32'(pend_mask[9]), 32'd1);
`endif
    step("starve_drain", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("starve_a3", 32'(A3), 32'd9);
    chk("starve_wd3", WD3, 32'hCAFE);
    chk("starve_release", 32'(alu_stall), 32'd0);
    step("starve_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Random traffic; ALU inputs are also toggled during stalls.
    for (int c = 0; c < 600; c++) begin
      av = ($urandom_range(0, 9) < 6);
      step("rand", av, 5'($urandom_range(0, 31)), $urandom(),
           $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom());
    end
    for (int c = 0; c < 8; c++) step("rand_flush", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Reset while draining with three results pending.
    for (int c = 0; c < 9; c++) begin
      step("pre_rst", 1, 5'd21, 32'(c), c < 3, 5'(13 + c), 32'hA0 + 32'(c));
    end
    chk("pre_rst_stall", 32'(alu_stall), 32'd1);
    chk("pre_rst_depth", 32'(m_rd.size()), 32'd3);
    #1 Reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    @(posedge clock);
    #1 Reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step("post_rst", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      chk("post_rst_we", 32'(RegWEn), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
